// File: rtl/display_pkg.sv
// display_pkg: shared digit count, BCD digit type and decade limit.
package display_pkg;
  localparam int DIGITS = 4;
  localparam logic [3:0] DIG_MAX = 4'd9;
  typedef logic [3:0] bcd_t;
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one up/down decade; co_o carries when up at 9 or borrows when down at 0.
module bcd_digit
  import display_pkg::*;
(
  input  bcd_t d_i,
  input  logic en_i,
  input  logic up_i,
  output bcd_t d_o,
  output logic co_o
);
  logic at_lim;
  assign at_lim = up_i ? (d_i == DIG_MAX) : (d_i == 4'd0);
  assign co_o = en_i & at_lim;
  assign d_o = !en_i ? d_i
             : at_lim ? (up_i ? 4'd0 : DIG_MAX)
             : (up_i ? d_i + 4'd1 : d_i - 4'd1);
endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: four-digit BCD up/down counter with multiplexed, zero-blanked display scan.
module bcd_scan_counter
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  input  logic        dec,
  output logic [15:0] count,
  output logic [3:0]  bcd,
  output logic [3:0]  dig_sel,
  output logic        ovf,
  output logic        unf
);
  localparam int PW = $clog2(SCAN_DIV);
  bcd_t [DIGITS-1:0] cnt_q, cnt_d;
  logic [DIGITS:0]   cy;
  logic [PW-1:0]     pre_q, pre_d;
  logic [1:0]        idx_q, idx_d;
  logic              ovf_q, unf_q, pre_wrap, blank;
  // clr gates the chain entry, so no carry can reach ovf/unf while clearing
  assign cy[0] = ~clr & (inc ^ dec);
  genvar i;
  for (i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .d_i (cnt_q[i]),
      .en_i(cy[i]),
      .up_i(inc),
      .d_o (cnt_d[i]),
      .co_o(cy[i+1])
    );
  end
  assign pre_wrap = pre_q == PW'(SCAN_DIV - 1);
  assign pre_d = pre_wrap ? '0 : pre_q + PW'(1);
  assign idx_d = pre_wrap ? idx_q + 2'd1 : idx_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      pre_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= clr ? '0 : cnt_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      ovf_q <= cy[DIGITS] & inc;
      unf_q <= cy[DIGITS] & dec;
    end
  end
  // a digit is blank when it and every more significant digit are zero
  assign blank = (idx_q != 2'd0) && ((cnt_q >> {idx_q, 2'b00}) == '0);
  assign count = cnt_q;
  assign bcd = cnt_q[idx_q];
  assign dig_sel = blank ? 4'b0000 : 4'b0001 << idx_q;
  assign ovf = ovf_q;
  assign unf = unf_q;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: vector table, corner sequences and randomized run against a decimal model.
`timescale 1ns/1ps
module tb_bcd_scan_counter;
  localparam int SD = 4;
  logic clk = 1'b0;
  logic rst, clr, inc, dec;
  logic [15:0] count;
  logic [3:0] bcd, dig_sel;
  logic ovf, unf;
  int checks = 0, errors = 0;
  int m_cnt = 0, m_t = 0;
  int m_ovf = 0, m_unf = 0;
  typedef struct {
    logic c, i, d;
    logic [15:0] cnt;
    logic o, u;
  } vec_t;
  vec_t tv[13];

  bcd_scan_counter #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc), .dec(dec),
    .count(count), .bcd(bcd), .dig_sel(dig_sel), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int pow10(int k);
    int p = 1;
    for (int j = 0; j < k; j++) p *= 10;
    return p;
  endfunction

  function automatic int dig(int v, int k);
    return (v / pow10(k)) % 10;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0d)", nm, act, exp, m_t);
    end
  endtask

  task automatic chk_model();
    int ix, pk;
    ix = (m_t / SD) % 4;
    pk = 0;
    for (int k = 0; k < 4; k++) pk |= dig(m_cnt, k) << (4 * k);
    chk("count", int'(count), pk);
    chk("bcd", int'(bcd), dig(m_cnt, ix));
    chk("dig_sel", int'(dig_sel), (ix > 0 && m_cnt < pow10(ix)) ? 0 : (1 << ix));
    chk("ovf", int'(ovf), m_ovf);
    chk("unf", int'(unf), m_unf);
  endtask

  task automatic step(logic c, logic i, logic d);
    clr = c; inc = i; dec = d;
    @(posedge clk); #1;
    if (c) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0;
    end else if (i && !d) begin
      m_ovf = int'(m_cnt == 9999); m_unf = 0; m_cnt = (m_cnt + 1) % 10000;
    end else if (d && !i) begin
      m_unf = int'(m_cnt == 0); m_ovf = 0; m_cnt = (m_cnt + 9999) % 10000;
    end else begin
      m_ovf = 0; m_unf = 0;
    end
    m_t++;
    chk_model();
  endtask

  task automatic do_reset();
    clr = 1'b0; inc = 1'b0; dec = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_count", int'(count), 0);
    chk("rst_dig_sel", int'(dig_sel), 1);
    chk("rst_bcd", int'(bcd), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_unf", int'(unf), 0);
    rst = 1'b0;
    m_cnt = 0; m_t = 0; m_ovf = 0; m_unf = 0;
  endtask

  initial begin
    tv[0]  = '{1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tv[10] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tv[12] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    do_reset();
    for (int n = 0; n < 13; n++) begin
      step(tv[n].c, tv[n].i, tv[n].d);
      chk($sformatf("tv%0d_count", n), int'(count), int'(tv[n].cnt));
      chk($sformatf("tv%0d_ovf", n), int'(ovf), int'(tv[n].o));
      chk($sformatf("tv%0d_unf", n), int'(unf), int'(tv[n].u));
    end
    // twelve increments with carry into the tens digit
    do_reset();
    repeat (12) step(1'b0, 1'b1, 1'b0);
    chk("inc12_count", int'(count), 'h0012);
    // fill to 9999 by increments, then wrap both ways
    do_reset();
    repeat (9999) step(1'b0, 1'b1, 1'b0);
    chk("fill_count", int'(count), 'h9999);
    step(1'b0, 1'b1, 1'b0);
    chk("wrap_count", int'(count), 'h0000);
    chk("wrap_ovf", int'(ovf), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("wrap_ovf_drop", int'(ovf), 0);
    step(1'b0, 1'b0, 1'b1);
    chk("under_count", int'(count), 'h9999);
    chk("under_unf", int'(unf), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("under_unf_drop", int'(unf), 0);
    repeat (5) step(1'b0, 1'b1, 1'b1);
    chk("incdec_hold", int'(count), 'h9999);
    step(1'b1, 1'b1, 1'b0);
    chk("clr_inc_count", int'(count), 'h0000);
    chk("clr_inc_ovf", int'(ovf), 0);
    // scan of 0050 with leading-zero blanking, aligned to an index-0 boundary
    do_reset();
    repeat (50) step(1'b0, 1'b1, 1'b0);
    repeat (13) step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      int sel_exp[4] = '{1, 2, 0, 0};
      int bcd_exp[4] = '{0, 5, 0, 0};
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("scan%0d_dig_sel", k), int'(dig_sel), sel_exp[k / 4]);
      chk($sformatf("scan%0d_bcd", k), int'(bcd), bcd_exp[k / 4]);
    end
    // reset at scan index 2 while an overflowing increment is pending
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    inc = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_dig_sel", int'(dig_sel), 1);
    chk("arst_bcd", int'(bcd), 0);
    chk("arst_ovf", int'(ovf), 0);
    @(posedge clk); #1;
    inc = 1'b0;
    chk("arst_ovf_edge", int'(ovf), 0);
    rst = 1'b0;
    m_cnt = 0; m_t = 0; m_ovf = 0; m_unf = 0;
    step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    chk("post_rst_idx0", int'(dig_sel), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("post_rst_idx1", int'(dig_sel), 2);
    // randomized run against the decimal model
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      step(logic'($urandom_range(0, 63) == 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)));
      for (int k = 0; k < 4; k++) chk("digit_range", int'(count[4*k +: 4] <= 4'd9), 1);
      chk("onehot", int'($countones(dig_sel) <= 1), 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clock cycles each digit is shown; legal range 2..2^20.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port clr, input, 1 bit: synchronous clear of the count to 0000.
REQ-005 The block SHALL have port inc, input, 1 bit: count up by one on each cycle it is high.
REQ-006 The block SHALL have port dec, input, 1 bit: count down by one on each cycle it is high.
REQ-007 The block SHALL have port count, output, 16 bits: four packed BCD digits; [3:0] is the units digit, [15:12] the thousands digit.
REQ-008 The block SHALL have port bcd, output, 4 bits: the digit currently scanned; feeds the 7-segment decoder.
REQ-009 The block SHALL have port dig_sel, output, 4 bits: one-hot active-high digit enable; bit 0 is the units digit.
REQ-010 The block SHALL have port ovf, output, 1 bit: one-cycle pulse on wrap from 9999 to 0000.
REQ-011 The block SHALL have port unf, output, 1 bit: one-cycle pulse on wrap from 0000 to 9999.

Function
REQ-012 Count update priority SHALL be: clr, then inc xor dec; inc and dec high together SHALL leave the count unchanged.
REQ-013 inc SHALL add 1 decimal with digit carry (…9 -> …0, next digit +1); count SHALL update on the edge where inc is sampled high.
REQ-014 dec SHALL subtract 1 decimal with digit borrow (…0 -> …9, next digit -1).
REQ-015 inc at 9999 SHALL yield 0000 and ovf=1 for exactly the following cycle; dec at 0000 SHALL yield 9999 and unf=1 for that cycle.
REQ-016 clr SHALL suppress ovf/unf in the same cycle, even with inc/dec high.
REQ-017 Each digit SHALL always hold a value 0..9.
REQ-018 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; when it wraps, the scan index SHALL advance 0->1->2->3->0.
REQ-019 bcd SHALL equal the count digit selected by the scan index, combinationally from registered state; a count change SHALL appear on bcd with zero added latency.
REQ-020 dig_sel SHALL be one-hot of the scan index, except when that digit is blanked.
REQ-021 Leading-zero blanking: at index i>0, if every digit j>=i is 0, dig_sel SHALL be 0000 while bcd still shows 0.
REQ-022 Index 0 SHALL never be blanked, so 0000 displays a single "0".
REQ-023 clr, inc and dec SHALL NOT disturb the prescaler or the scan index.

Reset
REQ-024 While rst=1, outputs SHALL be: count=0000, scan index=0, prescaler=0, bcd=0000, dig_sel=0001, ovf=0, unf=0.
REQ-025 Reset asserted mid-scan or mid-wrap SHALL take effect immediately, with no pulse emitted.
REQ-026 After rst is released, the first inc SHALL give count=0001, and the first index advance SHALL occur SCAN_DIV cycles after release.

Structure
REQ-027 Package display_pkg SHALL hold DIGITS=4, typedef bcd_t (logic [3:0]) and the digit-value limit 9.
REQ-028 Sub-module bcd_digit SHALL implement one decade (up/down, carry-in/borrow-in, carry-out/borrow-out) and SHALL be instantiated DIGITS times in a ripple chain.
REQ-029 ovf/unf SHALL be registered, and the prescaler width SHALL be $clog2(SCAN_DIV).

Verification (SCAN_DIV=4 in simulation)
REQ-030 Reset then 12 inc pulses -> count=0012; ovf and unf never high.
REQ-031 Load 9999 via inc pulses, then one more inc -> count=0000 and ovf high exactly 1 cycle; then one dec -> count=9999 and unf high 1 cycle.
REQ-032 inc and dec high together for 5 cycles -> count unchanged; clr with inc -> 0000 and no ovf.
REQ-033 count=0050, run 16 cycles -> dig_sel sequence 0001,0010,0000,0000, each held 4 cycles; bcd sequence 0,5,0,0.
REQ-034 Assert rst at scan index 2 during an inc -> immediately count=0000, dig_sel=0001, bcd=0, no ovf; next index step 4 cycles after release.
REQ-035 Random inc/dec/clr for 10k cycles -> count matches a modulo-10000 reference model, every digit <=9, and dig_sel has at most one bit set.
